// File: rtl/sram_arbiter.sv
// Two-port (CPU/DMA) arbiter for the shared data SRAM: CPU priority with a DMA starvation
// limit, req/ack handshake, programmable wait states. Optional DMA write fence: SRAM_ARB_PROTECT_EN.
//
//   state  | meaning
//   IDLE   | no access in flight; arbitrate and latch winner's we/addr/wdata
//   ACCESS | SRAM driven for WAIT_CYCLES+1 cycles; write strobe / read capture on the last
//   RESP   | one-cycle ack to the owner, then back to IDLE
module sram_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int WAIT_CYCLES  = 0,
  parameter int STARVE_LIMIT = 4
`ifdef SRAM_ARB_PROTECT_EN
  ,
  parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'('hF0)
`endif
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_write_en,
  output logic [DATA_W-1:0] sram_write_data,
  input  logic [DATA_W-1:0] sram_read_data,
  output logic [1:0]        owner,
  output logic              busy
`ifdef SRAM_ARB_PROTECT_EN
  ,
  output logic              dma_err
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0] OWN_NONE   = 2'b00;
  localparam logic [1:0] OWN_CPU    = 2'b01;
  localparam logic [1:0] OWN_DMA    = 2'b10;
  localparam logic [2:0] WAIT_INIT  = 3'(WAIT_CYCLES);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t              state_q, state_d;
  logic [2:0]          wait_q, wait_d;
  logic [3:0]          starve_q, starve_d;
  logic [1:0]          owner_q, owner_d;
  logic                we_q, we_d;
  logic                prot_q, prot_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
  logic                sram_we_q, sram_we_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dma_ack_q, dma_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                busy_q, busy_d;
`ifdef SRAM_ARB_PROTECT_EN
  logic                err_q, err_d;
`endif

  logic                dma_win;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    starve_d     = starve_q;
    owner_d      = owner_q;
    we_d         = we_q;
    prot_d       = prot_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
`ifdef SRAM_ARB_PROTECT_EN
    err_d        = 1'b0;
`endif
    dma_win   = dma_req && (!cpu_req || (starve_q == STARVE_MAX));
    sel_we    = dma_win ? dma_we    : cpu_we;
    sel_addr  = dma_win ? dma_addr  : cpu_addr;
    sel_wdata = dma_win ? dma_wdata : cpu_wdata;

    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          state_d      = ACCESS;
          wait_d       = WAIT_INIT;
          owner_d      = dma_win ? OWN_DMA : OWN_CPU;
          we_d         = sel_we;
          sram_addr_d  = sel_addr;
          sram_wdata_d = sel_we ? sel_wdata : '0;
          // CPU grants only count against DMA while DMA is actually waiting
          if (!dma_win && dma_req)
            starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 4'd1;
          else
            starve_d = 4'd0;
`ifdef SRAM_ARB_PROTECT_EN
          prot_d = dma_win && dma_we && (dma_addr >= PROT_BASE);
`else
          prot_d = 1'b0;
`endif
        end
      end
      ACCESS: begin
        if (wait_q == 3'd0) begin
          state_d = RESP;
          if (owner_q == OWN_DMA) begin
            dma_ack_d = 1'b1;
            if (!we_q) dma_rdata_d = sram_read_data;
`ifdef SRAM_ARB_PROTECT_EN
            err_d = prot_q;
`endif
          end else begin
            cpu_ack_d = 1'b1;
            if (!we_q) cpu_rdata_d = sram_read_data;
          end
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    // strobe is registered, so it is armed on the edge that enters the last ACCESS cycle
    sram_we_d = (state_d == ACCESS) && (wait_d == 3'd0) && we_d && !prot_d;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      starve_q     <= '0;
      owner_q      <= OWN_NONE;
      we_q         <= 1'b0;
      prot_q       <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_we_q    <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      busy_q       <= 1'b0;
`ifdef SRAM_ARB_PROTECT_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      starve_q     <= starve_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      prot_q       <= prot_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_we_q    <= sram_we_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      busy_q       <= busy_d;
`ifdef SRAM_ARB_PROTECT_EN
      err_q        <= err_d;
`endif
    end
  end

  assign cpu_ack         = cpu_ack_q;
  assign cpu_rdata       = cpu_rdata_q;
  assign dma_ack         = dma_ack_q;
  assign dma_rdata       = dma_rdata_q;
  assign sram_addr       = sram_addr_q;
  assign sram_write_en   = sram_we_q;
  assign sram_write_data = sram_wdata_q;
  assign owner           = owner_q;
  assign busy            = busy_q;
`ifdef SRAM_ARB_PROTECT_EN
  assign dma_err         = err_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: three instances (WAIT_CYCLES 0, 3, 2) each with a
// behavioural SRAM; scenario tasks compare against hand-computed values.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst_n [3];
  logic       cpu_req [3], cpu_we [3], dma_req [3], dma_we [3];
  logic [7:0] cpu_addr [3], cpu_wdata [3], dma_addr [3], dma_wdata [3];
  logic       cpu_ack [3], dma_ack [3], sram_write_en [3], busy [3];
  logic [7:0] cpu_rdata [3], dma_rdata [3];
  logic [7:0] sram_addr [3], sram_write_data [3], sram_read_data [3];
  logic [1:0] owner [3];
`ifdef SRAM_ARB_PROTECT_EN
  logic       dma_err [3];
`endif

  logic [7:0] mem [3][256];
  int we_cnt [3]   = '{default: 0};
  int cack_cnt [3] = '{default: 0};
  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_arbiter #(
      .WAIT_CYCLES ((g == 0) ? 0 : (g == 1) ? 3 : 2),
      .STARVE_LIMIT(4)
    ) u_dut (
      .clk            (clk),
      .arst_n         (arst_n[g]),
      .cpu_req        (cpu_req[g]),
      .cpu_we         (cpu_we[g]),
      .cpu_addr       (cpu_addr[g]),
      .cpu_wdata      (cpu_wdata[g]),
      .cpu_ack        (cpu_ack[g]),
      .cpu_rdata      (cpu_rdata[g]),
      .dma_req        (dma_req[g]),
      .dma_we         (dma_we[g]),
      .dma_addr       (dma_addr[g]),
      .dma_wdata      (dma_wdata[g]),
      .dma_ack        (dma_ack[g]),
      .dma_rdata      (dma_rdata[g]),
      .sram_addr      (sram_addr[g]),
      .sram_write_en  (sram_write_en[g]),
      .sram_write_data(sram_write_data[g]),
      .sram_read_data (sram_read_data[g]),
      .owner          (owner[g]),
      .busy           (busy[g])
`ifdef SRAM_ARB_PROTECT_EN
      ,
      .dma_err        (dma_err[g])
`endif
    );
    assign sram_read_data[g] = mem[g][sram_addr[g]];
  end

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (sram_write_en[g] === 1'b1) begin
        mem[g][sram_addr[g]] <= sram_write_data[g];
        we_cnt[g] <= we_cnt[g] + 1;
      end
      if (cpu_ack[g] === 1'b1) cack_cnt[g] <= cack_cnt[g] + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // full handshake; lat = cycles from req to ack (20 means no ack seen)
  task automatic run_access(input int g, input bit dma, input bit we, input logic [7:0] a,
                            input logic [7:0] d, output int lat, output logic [7:0] rd);
    if (dma) begin
      dma_req[g] = 1'b1; dma_we[g] = we; dma_addr[g] = a; dma_wdata[g] = d;
    end else begin
      cpu_req[g] = 1'b1; cpu_we[g] = we; cpu_addr[g] = a; cpu_wdata[g] = d;
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (((dma ? dma_ack[g] : cpu_ack[g]) !== 1'b1) && lat < 20);
    rd = dma ? dma_rdata[g] : cpu_rdata[g];
    if (dma) dma_req[g] = 1'b0; else cpu_req[g] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    for (int g = 0; g < 3; g++) arst_n[g] = 1'b0;
    tick();
    tick();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({owner[g], busy[g], cpu_ack[g], dma_ack[g], cpu_rdata[g], dma_rdata[g],
           sram_addr[g], sram_write_en[g], sram_write_data[g]} !== 38'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got owner=%b busy=%b cack=%b dack=%b crd=%h drd=%h sa=%h swe=%b swd=%h, expected all 0",
                 g, owner[g], busy[g], cpu_ack[g], dma_ack[g], cpu_rdata[g], dma_rdata[g],
                 sram_addr[g], sram_write_en[g], sram_write_data[g]);
      end
`ifdef SRAM_ARB_PROTECT_EN
      checks++;
      if (dma_err[g] !== 1'b0) begin
        errors++;
        $display("FAIL reset_dma_err[%0d]: got %b expected 0", g, dma_err[g]);
      end
`endif
    end
    for (int g = 0; g < 3; g++) arst_n[g] = 1'b1;
    tick();
  endtask

  task automatic test_cpu_write_read();
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 8'h10; cpu_wdata[0] = 8'hA5;
    tick();
    checks++;
    if ({sram_write_en[0], sram_addr[0], sram_write_data[0], owner[0], cpu_ack[0]} !==
        {1'b1, 8'h10, 8'hA5, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL wr_access: got swe=%b sa=%h swd=%h own=%b ack=%b expected 1 10 a5 01 0",
               sram_write_en[0], sram_addr[0], sram_write_data[0], owner[0], cpu_ack[0]);
    end
    tick();
    checks++;
    if ({cpu_ack[0], sram_write_en[0], busy[0]} !== 3'b101) begin
      errors++;
      $display("FAIL wr_ack: got ack=%b swe=%b busy=%b expected 1 0 1",
               cpu_ack[0], sram_write_en[0], busy[0]);
    end
    cpu_req[0] = 1'b0;
    tick();
    checks++;
    if ({cpu_ack[0], owner[0], busy[0], sram_addr[0]} !== {1'b0, 2'b00, 1'b0, 8'h10}) begin
      errors++;
      $display("FAIL wr_idle: got ack=%b own=%b busy=%b sa=%h expected 0 00 0 10",
               cpu_ack[0], owner[0], busy[0], sram_addr[0]);
    end
    checks++;
    if (we_cnt[0] !== 1) begin
      errors++;
      $display("FAIL wr_strobe_count: got %0d expected 1", we_cnt[0]);
    end
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 8'h10; cpu_wdata[0] = 8'h5A;
    tick();
    checks++;
    if ({sram_write_en[0], sram_write_data[0], sram_addr[0]} !== {1'b0, 8'h00, 8'h10}) begin
      errors++;
      $display("FAIL rd_access: got swe=%b swd=%h sa=%h expected 0 00 10",
               sram_write_en[0], sram_write_data[0], sram_addr[0]);
    end
    tick();
    checks++;
    if ({cpu_ack[0], cpu_rdata[0]} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL rd_ack: got ack=%b rdata=%h expected 1 a5", cpu_ack[0], cpu_rdata[0]);
    end
    cpu_req[0] = 1'b0;
    tick();
    checks++;
    if ({cpu_ack[0], cpu_rdata[0]} !== {1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL rd_hold: got ack=%b rdata=%h expected 0 a5", cpu_ack[0], cpu_rdata[0]);
    end
  endtask

  task automatic test_dma_wait();
    int lat;
    logic [7:0] rd;
    run_access(1, 1'b0, 1'b1, 8'h20, 8'h3C, lat, rd);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL w3_preload_latency: got %0d expected 5", lat);
    end
    dma_req[1] = 1'b1; dma_we[1] = 1'b0; dma_addr[1] = 8'h20; dma_wdata[1] = 8'hFF;
    for (int i = 1; i <= 4; i++) begin
      tick();
      dma_addr[1] = 8'h99;
      checks++;
      if ({sram_addr[1], busy[1], owner[1], dma_ack[1], sram_write_en[1]} !==
          {8'h20, 1'b1, 2'b10, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL w3_access_cycle%0d: got sa=%h busy=%b own=%b ack=%b swe=%b expected 20 1 10 0 0",
                 i, sram_addr[1], busy[1], owner[1], dma_ack[1], sram_write_en[1]);
      end
    end
    tick();
    checks++;
    if ({dma_ack[1], dma_rdata[1], busy[1]} !== {1'b1, 8'h3C, 1'b1}) begin
      errors++;
      $display("FAIL w3_ack: got ack=%b rdata=%h busy=%b expected 1 3c 1",
               dma_ack[1], dma_rdata[1], busy[1]);
    end
    dma_req[1] = 1'b0;
    tick();
    checks++;
    if ({dma_ack[1], busy[1], owner[1]} !== 4'b0000) begin
      errors++;
      $display("FAIL w3_idle: got ack=%b busy=%b own=%b expected 0 0 00",
               dma_ack[1], busy[1], owner[1]);
    end
  endtask

  task automatic test_starvation();
    int n = 0;
    logic [1:0] exp_who, got_who;
    cpu_we[0] = 1'b0; cpu_addr[0] = 8'h10;
    dma_we[0] = 1'b0; dma_addr[0] = 8'h10;
    cpu_req[0] = 1'b1; dma_req[0] = 1'b1;
    for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
      tick();
      checks++;
      if ((cpu_ack[0] & dma_ack[0]) !== 1'b0) begin
        errors++;
        $display("FAIL starve_overlap: got both acks high at cycle %0d expected at most one", cyc);
      end
      if (cpu_ack[0] === 1'b1 || dma_ack[0] === 1'b1) begin
        exp_who = (n == 4 || n == 9) ? 2'b10 : 2'b01;
        got_who = (dma_ack[0] === 1'b1) ? 2'b10 : 2'b01;
        checks++;
        if (got_who !== exp_who) begin
          errors++;
          $display("FAIL starve_order[%0d]: got grant %b expected %b", n, got_who, exp_who);
        end
        n++;
        if (n == 10) begin
          cpu_req[0] = 1'b0;
          dma_req[0] = 1'b0;
        end
      end
    end
    cpu_req[0] = 1'b0;
    dma_req[0] = 1'b0;
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL starve_grant_count: got %0d expected 10", n);
    end
    tick();
  endtask

  task automatic test_both_same_cycle();
    int lat;
    logic [7:0] rd;
    run_access(0, 1'b0, 1'b1, 8'h30, 8'h11, lat, rd);
    run_access(0, 1'b0, 1'b1, 8'h31, 8'h22, lat, rd);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL both_preload_latency: got %0d expected 2", lat);
    end
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 8'h30;
    dma_req[0] = 1'b1; dma_we[0] = 1'b0; dma_addr[0] = 8'h31;
    tick();
    checks++;
    if (owner[0] !== 2'b01) begin
      errors++;
      $display("FAIL both_first_owner: got %b expected 01", owner[0]);
    end
    tick();
    checks++;
    if ({cpu_ack[0], cpu_rdata[0], dma_ack[0]} !== {1'b1, 8'h11, 1'b0}) begin
      errors++;
      $display("FAIL both_cpu_ack: got cack=%b crd=%h dack=%b expected 1 11 0",
               cpu_ack[0], cpu_rdata[0], dma_ack[0]);
    end
    cpu_req[0] = 1'b0;
    tick();
    tick();
    checks++;
    if (owner[0] !== 2'b10) begin
      errors++;
      $display("FAIL both_second_owner: got %b expected 10", owner[0]);
    end
    tick();
    checks++;
    if ({dma_ack[0], dma_rdata[0], cpu_rdata[0], cpu_ack[0]} !== {1'b1, 8'h22, 8'h11, 1'b0}) begin
      errors++;
      $display("FAIL both_dma_ack: got dack=%b drd=%h crd=%h cack=%b expected 1 22 11 0",
               dma_ack[0], dma_rdata[0], cpu_rdata[0], cpu_ack[0]);
    end
    dma_req[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int lat;
    logic [7:0] rd;
    cpu_req[2] = 1'b1; cpu_we[2] = 1'b1; cpu_addr[2] = 8'h08; cpu_wdata[2] = 8'h55;
    tick();
    tick();
    checks++;
    if ({busy[2], sram_write_en[2]} !== 2'b10) begin
      errors++;
      $display("FAIL rst_pre: got busy=%b swe=%b expected 1 0", busy[2], sram_write_en[2]);
    end
    arst_n[2] = 1'b0;
    cpu_req[2] = 1'b0;
    tick();
    checks++;
    if ({owner[2], busy[2], cpu_ack[2], dma_ack[2], cpu_rdata[2], dma_rdata[2],
         sram_addr[2], sram_write_en[2], sram_write_data[2]} !== 38'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got own=%b busy=%b cack=%b sa=%h swe=%b swd=%h expected all 0",
               owner[2], busy[2], cpu_ack[2], sram_addr[2], sram_write_en[2], sram_write_data[2]);
    end
    arst_n[2] = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if ({cack_cnt[2], we_cnt[2]} !== 64'd0) begin
      errors++;
      $display("FAIL rst_no_ack_no_write: got acks=%0d strobes=%0d expected 0 0",
               cack_cnt[2], we_cnt[2]);
    end
    run_access(2, 1'b0, 1'b1, 8'h09, 8'h66, lat, rd);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL rst_after_latency: got %0d expected 4", lat);
    end
    run_access(2, 1'b0, 1'b0, 8'h09, 8'h00, lat, rd);
    checks++;
    if ({rd, we_cnt[2]} !== {8'h66, 32'd1}) begin
      errors++;
      $display("FAIL rst_after_readback: got rdata=%h strobes=%0d expected 66 1", rd, we_cnt[2]);
    end
  endtask

`ifdef SRAM_ARB_PROTECT_EN
  task automatic test_protect();
    int lat;
    int base;
    logic [7:0] rd;
    base = we_cnt[0];
    dma_req[0] = 1'b1; dma_we[0] = 1'b1; dma_addr[0] = 8'hF4; dma_wdata[0] = 8'h77;
    tick();
    checks++;
    if ({sram_write_en[0], dma_err[0], dma_ack[0], owner[0]} !== 5'b00010) begin
      errors++;
      $display("FAIL prot_access: got swe=%b err=%b ack=%b own=%b expected 0 0 0 10",
               sram_write_en[0], dma_err[0], dma_ack[0], owner[0]);
    end
    tick();
    checks++;
    if ({dma_ack[0], dma_err[0], sram_write_en[0]} !== 3'b110) begin
      errors++;
      $display("FAIL prot_ack_err: got ack=%b err=%b swe=%b expected 1 1 0",
               dma_ack[0], dma_err[0], sram_write_en[0]);
    end
    dma_req[0] = 1'b0;
    tick();
    checks++;
    if ({dma_err[0], dma_ack[0], we_cnt[0] - base} !== {2'b00, 32'd0}) begin
      errors++;
      $display("FAIL prot_after: got err=%b ack=%b strobes=%0d expected 0 0 0",
               dma_err[0], dma_ack[0], we_cnt[0] - base);
    end
    run_access(0, 1'b0, 1'b1, 8'hF4, 8'h77, lat, rd);
    run_access(0, 1'b1, 1'b0, 8'hF4, 8'h00, lat, rd);
    checks++;
    if ({rd, we_cnt[0] - base} !== {8'h77, 32'd1}) begin
      errors++;
      $display("FAIL prot_cpu_write: got rdata=%h strobes=%0d expected 77 1", rd, we_cnt[0] - base);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < 3; g++) begin
      arst_n[g] = 1'b0;
      cpu_req[g] = 1'b0; cpu_we[g] = 1'b0; cpu_addr[g] = '0; cpu_wdata[g] = '0;
      dma_req[g] = 1'b0; dma_we[g] = 1'b0; dma_addr[g] = '0; dma_wdata[g] = '0;
    end
    test_reset();
    test_cpu_write_read();
    test_dma_wait();
    test_starvation();
    test_both_same_cycle();
    test_reset_mid_access();
`ifdef SRAM_ARB_PROTECT_EN
    test_protect();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 8-bit data SRAM between two requesters: the CPU control unit (load/store path) and a DMA/debug port.
- Fixed priority to the CPU, with a starvation limit that guarantees DMA forward progress.
- Uses a req/ack handshake per requester and sequences SRAM accesses with a programmable number of wait states.
- Sits between the control unit's sram_* signals and the SRAM macro.

Parameters:
- ADDR_W, 8, SRAM address width
- DATA_W, 8, SRAM data width
- WAIT_CYCLES, 0, extra SRAM access cycles (0..7)
- STARVE_LIMIT, 4, max consecutive CPU grants while dma_req is pending (1..15)

Ports:
- clk  in  1  system clock
- arst_n  in  1  reset
- cpu_req  in  1  CPU access request; hold until cpu_ack
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same as the cpu_* ports, for DMA
- sram_addr  out  ADDR_W  SRAM address
- sram_write_en  out  1  SRAM write strobe
- sram_write_data  out  DATA_W  SRAM write data
- sram_read_data  in  DATA_W  SRAM read data
- owner  out  2  00 none, 01 CPU, 10 DMA
- busy  out  1  high when state is not IDLE

Interface: one clock, clk; reset arst_n is synchronous and active-low. All outputs are registered.

Behaviour:
- Reset (arst_n low at a clk edge):
  - state goes to IDLE; all outputs 0; wait counter and starve counter 0.
  - Any in-flight access is abandoned with no ack; sram_write_en drops at that edge.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, select a winner, latch its we/addr/wdata, set owner, load wait counter with WAIT_CYCLES, and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - CPU wins if cpu_req is high, unless dma_req is high and starve_cnt == STARVE_LIMIT; in that case DMA wins.
  - starve_cnt increments on each CPU grant while dma_req is high, saturating at STARVE_LIMIT.
  - starve_cnt clears on a DMA grant, or on any grant where dma_req is low.
- ACCESS:
  - sram_addr and sram_write_data are driven from the latched values for the whole state.
  - The state lasts WAIT_CYCLES+1 cycles; the wait counter decrements each cycle.
  - sram_write_en is high only in the final ACCESS cycle, and only for writes.
  - In the final cycle, reads capture sram_read_data; next state is RESP.
- RESP:
  - Pulse the owner's ack for exactly 1 cycle.
  - For reads, update that port's rdata at the same edge; for writes, rdata is unchanged.
  - sram_write_en is 0; next state is IDLE; owner returns to 00 on entering IDLE.
- Latency: req first seen in IDLE at cycle N gives ack in cycle N+WAIT_CYCLES+2.
- Max throughput: one access per WAIT_CYCLES+3 cycles.
- Requester rules:
  - Deassert req in the cycle after ack unless issuing a new access. A req still high in IDLE after its ack is treated as a new request.
  - Requests raised during ACCESS/RESP wait; there is no preemption.
  - A req dropped before ack is a protocol violation. The latched access still completes, and the ack is still pulsed.
- Address/data inputs are sampled only in IDLE; changes afterwards are ignored.
- rdata holds its last value between reads. The other port's ack and rdata are never disturbed.
- sram_addr holds its last value in IDLE/RESP. sram_write_data is 0 for reads.

Optional Feature:
- Macro: SRAM_ARB_PROTECT_EN.
- When defined:
  - Adds parameter PROT_BASE (default 8'hF0) and output port dma_err (1 bit).
  - A DMA write with addr >= PROT_BASE still traverses ACCESS/RESP with normal latency, but sram_write_en stays 0.
  - dma_err pulses together with dma_ack; dma_err is 0 otherwise and on reset.
  - CPU writes and DMA reads are never blocked.
- When undefined: no dma_err port, no PROT_BASE parameter, all writes pass.

Test Plan:
- WAIT_CYCLES=0, CPU writes 8'hA5 to 8'h10, then reads 8'h10 → sram_write_en pulses one cycle with addr 10/data A5. cpu_ack arrives 2 cycles after req. Read returns cpu_rdata=A5.
- WAIT_CYCLES=3, DMA read of 8'h20 (SRAM holds 8'h3C) → sram_addr=20 for 4 cycles, dma_ack 5 cycles after req, dma_rdata=3C, busy high throughout.
- cpu_req and dma_req held continuously, STARVE_LIMIT=4 → grant order is CPU×4, DMA, CPU×4, DMA; acks never overlap.
- Both req asserted in the same IDLE cycle, starve_cnt=0 → CPU served first, DMA served immediately after (owner 01 then 10). cpu_rdata is unchanged by the DMA read.
- arst_n low during ACCESS of a CPU write, WAIT_CYCLES=2 → no cpu_ack, sram_write_en never asserted, all outputs 0. The first req after reset is served normally.
- SRAM_ARB_PROTECT_EN defined, PROT_BASE=F0:
  - DMA write of 8'h77 to F4 → dma_ack and dma_err pulse together, sram_write_en stays 0.
  - CPU write of 8'h77 to F4 → written normally.
